// File: rtl/tanh_act_pkg.sv
// Shared types and constant helpers for the fixed-point activation pipelines.
// Segment boundaries and offsets scale with the number of fractional bits.
package tanh_act_pkg;

    localparam logic MODE_PWL  = 1'b0;
    localparam logic MODE_HARD = 1'b1;

    // Per-sample flags carried from the segment stage to the output stage.
    typedef struct packed {
        logic sign;
        logic sat;
    } stage_flags_t;

    // Upper (exclusive) magnitude bound of PWL segment seg: one/2, one, 2*one.
    function automatic int seg_bound(input int frac_w, input int seg);
        case (seg)
            32'sd0:  return 32'sd1 <<< (frac_w - 32'sd1);
            32'sd1:  return 32'sd1 <<< frac_w;
            default: return 32'sd1 <<< (frac_w + 32'sd1);
        endcase
    endfunction

    // Additive offset of PWL segment seg: 0, one/4, 5*one/8, 13*one/16.
    function automatic int seg_offset(input int frac_w, input int seg);
        case (seg)
            32'sd0:  return 32'sd0;
            32'sd1:  return 32'sd1 <<< (frac_w - 32'sd2);
            32'sd2:  return 32'sd5 * (32'sd1 <<< (frac_w - 32'sd3));
            default: return 32'sd13 * (32'sd1 <<< (frac_w - 32'sd4));
        endcase
    endfunction

endpackage

// File: rtl/tanh_pwl_seg.sv
// Combinational segment select, shift-add and clamp on an unsigned magnitude.
// Hard mode clips to one; PWL mode follows a four-segment tanh approximation.
import tanh_act_pkg::*;

module tanh_pwl_seg #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 5
) (
    input  logic [DATA_W-1:0] mag,
    input  logic              mode,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    localparam logic [DATA_W:0] B0     = (DATA_W+1)'(seg_bound(FRAC_W, 32'sd0));
    localparam logic [DATA_W:0] ONE    = (DATA_W+1)'(seg_bound(FRAC_W, 32'sd1));
    localparam logic [DATA_W:0] B2     = (DATA_W+1)'(seg_bound(FRAC_W, 32'sd2));
    localparam logic [DATA_W:0] OFF1   = (DATA_W+1)'(seg_offset(FRAC_W, 32'sd1));
    localparam logic [DATA_W:0] OFF2   = (DATA_W+1)'(seg_offset(FRAC_W, 32'sd2));
    localparam logic [DATA_W:0] OFF3   = (DATA_W+1)'(seg_offset(FRAC_W, 32'sd3));
    localparam logic [DATA_W:0] ONE_M1 = ONE - {{DATA_W{1'b0}}, 1'b1};

    logic [DATA_W:0] mag_w_s;
    logic [DATA_W:0] y_raw_s;

    // Segment select and shift-add; the extra bit keeps the pre-clamp sum exact.
    always_comb begin
        mag_w_s = {1'b0, mag};
        y_raw_s = '0;
        sat     = 1'b0;
        y       = '0;
        if (mode == MODE_HARD) begin
            if (mag_w_s >= ONE) begin
                y_raw_s = ONE;
                sat     = 1'b1;
            end else begin
                y_raw_s = mag_w_s;
                sat     = 1'b0;
            end
            y = y_raw_s[DATA_W-1:0];
        end else begin
            if (mag_w_s < B0) begin
                y_raw_s = mag_w_s;
            end else if (mag_w_s < ONE) begin
                y_raw_s = (mag_w_s >> 3'd1) + OFF1;
            end else if (mag_w_s < B2) begin
                y_raw_s = (mag_w_s >> 3'd3) + OFF2;
            end else begin
                y_raw_s = (mag_w_s >> 3'd5) + OFF3;
                sat     = 1'b1;
            end
            if (y_raw_s > ONE_M1) begin
                y = ONE_M1[DATA_W-1:0];
            end else begin
                y = y_raw_s[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tanh_pwl_pipe.sv
// Three-stage valid/ready tanh activation: |x| -> segment/clamp -> re-sign.
// Counts delivered saturated results for accuracy profiling.
import tanh_act_pkg::*;

module tanh_pwl_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              sat_clr,
    output logic [CNT_W-1:0]  sat_cnt
);

    logic              s1_v_r, s2_v_r, s3_v_r;
    logic              s1_sign_r, s1_mode_r;
    logic [DATA_W-1:0] s1_mag_r;
    stage_flags_t      s2_flags_r;
    logic [DATA_W-1:0] s2_y_r;
    logic              s3_sat_r;
    logic [DATA_W-1:0] out_data_r;
    logic [CNT_W-1:0]  sat_cnt_r;

    logic              s1_rdy_s, s2_rdy_s, s3_rdy_s;
    logic [DATA_W-1:0] in_mag_s;
    logic [DATA_W-1:0] seg_y_s;
    logic              seg_sat_s;

    // A stage may load when empty or when its contents move on this cycle.
    assign s3_rdy_s = !s3_v_r || out_ready;
    assign s2_rdy_s = !s2_v_r || s3_rdy_s;
    assign s1_rdy_s = !s1_v_r || s2_rdy_s;
    assign in_ready = s1_rdy_s;

    // The most negative input maps to 2^(DATA_W-1), still exact as unsigned.
    assign in_mag_s = in_data[DATA_W-1] ? (~in_data + {{(DATA_W-1){1'b0}}, 1'b1}) : in_data;

    tanh_pwl_seg #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_seg (
        .mag  (s1_mag_r),
        .mode (s1_mode_r),
        .y    (seg_y_s),
        .sat  (seg_sat_s)
    );

    // Stage 1: capture sign, magnitude and mode of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r    <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_mode_r <= MODE_PWL;
            s1_mag_r  <= '0;
        end else if (s1_rdy_s) begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= in_data[DATA_W-1];
                s1_mode_r <= mode;
                s1_mag_r  <= in_mag_s;
            end
        end
    end

    // Stage 2: register the clamped magnitude result and its saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r     <= 1'b0;
            s2_flags_r <= '0;
            s2_y_r     <= '0;
        end else if (s2_rdy_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_flags_r.sign <= s1_sign_r;
                s2_flags_r.sat  <= seg_sat_s;
                s2_y_r          <= seg_y_s;
            end
        end
    end

    // Stage 3: restore the sign; holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v_r     <= 1'b0;
            s3_sat_r   <= 1'b0;
            out_data_r <= '0;
        end else if (s3_rdy_s) begin
            s3_v_r <= s2_v_r;
            if (s2_v_r) begin
                s3_sat_r   <= s2_flags_r.sat;
                out_data_r <= s2_flags_r.sign ? (~s2_y_r + {{(DATA_W-1){1'b0}}, 1'b1}) : s2_y_r;
            end
        end
    end

    // Saturation counter: clear wins, otherwise count delivered saturated results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_r <= '0;
        end else if (sat_clr) begin
            sat_cnt_r <= '0;
        end else if (s3_v_r && out_ready && s3_sat_r && (sat_cnt_r != {CNT_W{1'b1}})) begin
            sat_cnt_r <= sat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = s3_v_r;
    assign out_data  = out_data_r;
    assign sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Scoreboard bench for tanh_pwl_pipe: directed vectors with hand-computed results.
module tb_tanh_pwl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] sat_cnt;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  sb_q[$];
    bit          saw_bp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    logic [7:0] t1_in[7]  = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h7f, 8'h80, 8'h00};
    logic [7:0] t1_exp[7] = '{8'h08, 8'h10, 8'h18, 8'h1c, 8'h1d, 8'he2, 8'h00};
    logic [7:0] t2_in[4]  = '{8'h14, 8'h40, 8'h80, 8'he0};
    logic [7:0] t2_exp[4] = '{8'h14, 8'h20, 8'he0, 8'he0};
    logic [7:0] t3_in[10]  = '{8'h03, 8'hfb, 8'h0c, 8'h14, 8'he8, 8'h28, 8'h46, 8'h9c, 8'h0f, 8'h1f};
    logic [7:0] t3_exp[10] = '{8'h03, 8'hfb, 8'h0c, 8'h12, 8'hec, 8'h19, 8'h1c, 8'he3, 8'h0f, 8'h17};

    tanh_pwl_pipe #(.DATA_W(8), .FRAC_W(5), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Offer one sample at a negedge, retry until accepted; expected result queued on acceptance.
    task automatic send(input logic [7:0] d, input logic m, input logic [7:0] exp);
        bit done = 1'b0;
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            if (!in_ready) saw_bp = 1'b1;
            if (in_ready) begin
                sb_q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: sample %0h not accepted within 100 cycles", d);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(negedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic ordy, input logic clr);
        @(posedge clk);
        #2;
        out_ready = ordy;
        sat_clr   = clr;
    endtask

    // Monitor: pop and compare on each output transfer; check stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got %0h, required no output", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: PWL back-to-back
        for (int i = 0; i < 7; i++) send(t1_in[i], 1'b0, t1_exp[i]);
        drain();
        check("t1_sat_cnt", 32'(sat_cnt), 32'd3);

        // 2: hard clip
        for (int i = 0; i < 4; i++) send(t2_in[i], 1'b1, t2_exp[i]);
        drain();
        check("t2_sat_cnt", 32'(sat_cnt), 32'd6);

        // 3: backpressure in the middle of a 10-sample stream
        fork
            for (int i = 0; i < 10; i++) send(t3_in[i], 1'b0, t3_exp[i]);
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();
        check("t3_in_ready_fell", 32'(saw_bp), 32'd1);
        check("t3_sat_cnt", 32'(sat_cnt), 32'd8);

        // 4: mode toggles per sample on a constant input
        for (int i = 0; i < 4; i++) send(8'h40, i[0], (i[0] ? 8'h20 : 8'h1c));
        drain();
        check("t4_sat_cnt", 32'(sat_cnt), 32'd12);

        // 5: async reset with three samples in flight
        set_ctl(1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) send(8'h40, 1'b0, 8'h1c);
        check("t5_full_before_rst", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("t5_rst_out_data", 32'(out_data), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_ctl(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_stale", 32'(out_valid), 32'd0);
        end

        // 6: counter saturation, then clear against a saturating transfer
        for (int i = 0; i < 65540; i++) send(8'h40, 1'b0, 8'h1c);
        drain();
        check("t6_sat_hold", 32'(sat_cnt), 32'hffff);
        set_ctl(1'b0, 1'b0);
        @(negedge clk);
        send(8'h40, 1'b0, 8'h1c);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        check("t6_out_valid_ready", 32'(out_valid), 32'd1);
        set_ctl(1'b1, 1'b1);
        set_ctl(1'b1, 1'b0);
        @(negedge clk);
        check("t6_clr_priority", 32'(sat_cnt), 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
